t_ff_counter: RTL and testbench

Parametrised up/down counter built from an array of T flip-flop cells, the multi-bit successor to the single master-slave T flip-flop. Adds programmable modulus, direction, synchronous load, wrap-or-saturate at the boundaries, a terminal-count strobe and a sticky overflow flag. It is used as a general event or divide counter in the sequential-circuit library.

---
 rtl/t_ff_pkg.sv | 17 +
 rtl/t_ff_cell.sv | 23 ++
 rtl/t_ff_counter.sv | 86 ++++++++
 tb/tb_t_ff_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// Shared constants and helpers for the T-flip-flop counter family.
package t_ff_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_HOLD = 1;

  function automatic logic [31:0] clamp_max(input logic [31:0] value, input logic [31:0] max);
    logic [31:0] res;
    if (value > max) begin
      res = max;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop: toggles on the rising clock edge when t is high.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (t) begin
      q_q <= ~q_q;
    end else begin
      q_q <= q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/t_ff_counter.sv
// Up/down counter with modulus MAX, load, wrap/saturate and sticky overflow,
// where every count bit is held in a T cell toggled by q ^ q_next.
module t_ff_counter
  import t_ff_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = (2 ** WIDTH) - 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] t_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             ovf_d;
  logic             ovf_q;

  assign at_max_s  = (cnt_s == MAX_W);
  assign at_zero_s = (cnt_s == {WIDTH{1'b0}});

  always_comb begin
    cnt_d = cnt_s;
    ovf_d = ovf_q;
    if (load) begin
      cnt_d = WIDTH'(clamp_max(32'(d), 32'(MAX_W)));
      ovf_d = 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max_s) begin
          cnt_d = (SATURATE == MODE_HOLD) ? MAX_W : {WIDTH{1'b0}};
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_s + WIDTH'(1);
        end
      end else begin
        if (at_zero_s) begin
          cnt_d = (SATURATE == MODE_HOLD) ? {WIDTH{1'b0}} : MAX_W;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_s - WIDTH'(1);
        end
      end
    end else begin
      cnt_d = cnt_s;
      ovf_d = ovf_q;
    end
  end

  assign t_s = cnt_s ^ cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_s[i]),
      .q   (cnt_s[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // rst gating keeps tc low while the cells are held at zero
  assign tc  = ~rst & en & ~load & ((up & at_max_s) | (~up & at_zero_s));
  assign q   = cnt_s;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_t_ff_counter.sv
// Directed bench: wrap (MAX=9), saturate (MAX=9) and full-range (MAX=15) counters
// share one stimulus stream; each scenario checks the relevant instance.
module tb_t_ff_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] d;
  logic [3:0] q_w, q_s, q_f;
  logic       tc_w, tc_s, tc_f;
  logic       ovf_w, ovf_s, ovf_f;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  t_ff_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q_w), .tc(tc_w), .ovf(ovf_w));

  t_ff_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q_s), .tc(tc_s), .ovf(ovf_s));

  t_ff_counter #(.WIDTH(4), .MAX(15), .SATURATE(0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q_f), .tc(tc_f), .ovf(ovf_f));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_q;
    int exp_ovf;

    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = 4'd0;
    step();
    step();
    chk("reset_q", 8'(q_w), 8'd0);
    chk("reset_ovf", 8'(ovf_w), 8'd0);
    chk("reset_tc", 8'(tc_w), 8'd0);

    // Asynchronous reset mid-count at 6
    rst = 1'b0; load = 1'b1; d = 4'd6;
    step();
    chk("load6_q", 8'(q_w), 8'd6);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", 8'(q_w), 8'd0);
    chk("async_rst_ovf", 8'(ovf_w), 8'd0);
    chk("async_rst_tc", 8'(tc_w), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_q0", 8'(q_w), 8'd0);
    step();
    chk("post_rst_q1", 8'(q_w), 8'd1);
    step();
    chk("post_rst_q2", 8'(q_w), 8'd2);

    // Up-wrap, MAX=9
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    exp_q = 0; exp_ovf = 0;
    chk("wrap_start_q", 8'(q_w), 8'd0);
    for (int i = 0; i < 12; i++) begin
      chk("wrap_tc", 8'(tc_w), (exp_q == 9) ? 8'd1 : 8'd0);
      step();
      if (exp_q == 9) begin
        exp_q = 0; exp_ovf = 1;
      end else begin
        exp_q = exp_q + 1;
      end
      chk("wrap_q", 8'(q_w), 8'(exp_q));
      chk("wrap_ovf", 8'(ovf_w), 8'(exp_ovf));
    end

    // Down-saturate, MAX=9
    load = 1'b1; d = 4'd2;
    step();
    chk("sat_load_q", 8'(q_s), 8'd2);
    chk("sat_load_ovf", 8'(ovf_s), 8'd0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    exp_q = 2; exp_ovf = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sat_tc", 8'(tc_s), (exp_q == 0) ? 8'd1 : 8'd0);
      step();
      if (exp_q == 0) begin
        exp_ovf = 1;
      end else begin
        exp_q = exp_q - 1;
      end
      chk("sat_q", 8'(q_s), 8'(exp_q));
      chk("sat_ovf", 8'(ovf_s), 8'(exp_ovf));
    end
    // Wrap counter went 2,1,0,9,8,7 in the same window
    chk("down_wrap_q", 8'(q_w), 8'd7);
    chk("down_wrap_ovf", 8'(ovf_w), 8'd1);

    // Load clamp and priority over a boundary event
    load = 1'b1; d = 4'd13; en = 1'b1; up = 1'b1;
    #1;
    chk("load_tc_low", 8'(tc_w), 8'd0);
    step();
    chk("clamp_q", 8'(q_w), 8'd9);
    chk("clamp_ovf", 8'(ovf_w), 8'd0);
    chk("clamp_q_f", 8'(q_f), 8'd13);
    d = 4'd4;
    #1;
    chk("load_wrap_tc", 8'(tc_w), 8'd0);
    step();
    chk("load_wins_q", 8'(q_w), 8'd4);
    chk("load_wins_ovf", 8'(ovf_w), 8'd0);

    // Enable and direction
    d = 4'd5;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_q", 8'(q_w), 8'd5);
    end
    en = 1'b1; up = 1'b1;
    step(); chk("dir_q6", 8'(q_w), 8'd6);
    step(); chk("dir_q7", 8'(q_w), 8'd7);
    up = 1'b0;
    step(); chk("dir_q6b", 8'(q_w), 8'd6);
    step(); chk("dir_q5", 8'(q_w), 8'd5);
    step(); chk("dir_q4", 8'(q_w), 8'd4);
    chk("dir_ovf", 8'(ovf_w), 8'd0);

    // Full range, MAX=15: plain modulo-16
    load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    exp_q = 0; exp_ovf = 0;
    for (int i = 0; i < 20; i++) begin
      chk("full_tc", 8'(tc_f), (exp_q == 15) ? 8'd1 : 8'd0);
      step();
      if (exp_q == 15) exp_ovf = 1;
      exp_q = (exp_q + 1) % 16;
      chk("full_q", 8'(q_f), 8'(exp_q));
      chk("full_ovf", 8'(ovf_f), 8'(exp_ovf));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
